// File: rtl/jtdsp16_do_cache.sv
// Loop-body instruction cache for DSP16 do/redo loops.
// Captures N ROM words on the first pass, then replays them with the ROM port idle.
module jtdsp16_do_cache #(
    parameter int unsigned DEPTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic        do_en,
    input  logic        do_flush,
    input  logic        pc_halt,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic        rom_cs,
    output logic        hit,
    output logic [3:0]  debug_len
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 4;
    localparam int unsigned KW = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] len, len_nx;
    logic [PW-1:0] wr_ptr, wr_nx;
    logic [PW-1:0] rd_ptr, rd_nx;
    logic [PW-1:0] len_last;
    logic [PW-1:0] do_n;
    logic          k_one;
    logic          mem_we;
    logic          rom_cs_nx;
    logic          hit_nx;
    logic [DW-1:0] mem [DEPTH];

    assign do_n      = do_data[10:7];
    assign k_one     = (do_data[6:0] == KW'(1));
    assign len_last  = PW'(len - PW'(1));
    assign debug_len = len;

    // State and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            len    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rom_cs <= 1'b1;
            hit    <= 1'b0;
        end else if (cen) begin
            state  <= state_nx;
            len    <= len_nx;
            wr_ptr <= wr_nx;
            rd_ptr <= rd_nx;
            rom_cs <= rom_cs_nx;
            hit    <= hit_nx;
        end
    end

    // Cache storage; contents survive flushes so redo can replay them
    always_ff @(posedge clk) begin
        if (!rst && cen && mem_we) begin
            mem[wr_ptr] <= rom_data;
        end
    end

    // Next state: new do > redo > abort > stall > normal fill/replay progress
    always_comb begin
        state_nx = state;
        len_nx   = len;
        wr_nx    = wr_ptr;
        rd_nx    = rd_ptr;
        mem_we   = 1'b0;
        if (do_start && (do_n != '0)) begin
            len_nx   = do_n;
            wr_nx    = '0;
            rd_nx    = '0;
            state_nx = (do_n == PW'(1) && k_one) ? IDLE : FILL;
        end else if (do_start) begin
            if (len != '0) begin
                state_nx = REPLAY;
                rd_nx    = '0;
            end
        end else if (state != IDLE && !do_en) begin
            state_nx = IDLE;
        end else if (!pc_halt) begin
            case (state)
                FILL: begin
                    mem_we = 1'b1;
                    wr_nx  = PW'(wr_ptr + PW'(1));
                    if (wr_ptr == len_last) begin
                        rd_nx    = '0;
                        state_nx = do_flush ? IDLE : REPLAY;
                    end
                end
                REPLAY: begin
                    if (do_flush) begin
                        state_nx = IDLE;
                        rd_nx    = '0;
                    end else begin
                        rd_nx = (rd_ptr == len_last) ? '0 : PW'(rd_ptr + PW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: instr is a zero-latency mux, rom_cs/hit track the state being entered
    always_comb begin
        instr     = rom_data;
        rom_cs_nx = (state_nx != REPLAY);
        hit_nx    = (state_nx == REPLAY);
        if (state == REPLAY) begin
            instr = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Scoreboard bench for jtdsp16_do_cache: directed loop scenarios then random traffic.
module tb_jtdsp16_do_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        do_start;
    logic [10:0] do_data;
    logic        do_en;
    logic        do_flush;
    logic        pc_halt;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        rom_cs;
    logic        hit;
    logic [3:0]  debug_len;

    always #5 clk = ~clk;

    jtdsp16_do_cache #(.DEPTH(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .do_start  (do_start),
        .do_data   (do_data),
        .do_en     (do_en),
        .do_flush  (do_flush),
        .pc_halt   (pc_halt),
        .rom_data  (rom_data),
        .instr     (instr),
        .rom_cs    (rom_cs),
        .hit       (hit),
        .debug_len (debug_len)
    );

    typedef struct {
        logic [15:0] instr;
        bit          chk_instr;
        logic        rom_cs;
        logic        hit;
        logic [3:0]  len;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: loop phase, body length, position in the body stream
    int          phase = 0;  // 0 idle, 1 capturing, 2 playing back
    int          m_len = 0;
    int          pos   = 0;
    logic [15:0] words [16];
    bit          known [16];

    localparam logic [15:0] WA = 16'hA001;
    localparam logic [15:0] WB = 16'hB002;
    localparam logic [15:0] WC = 16'hC003;

    function automatic void chk(string what, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endfunction

    // Apply the effect of the inputs sampled at the edge that just happened
    task automatic model_edge();
        int n;
        int k;
        n = int'(do_data[10:7]);
        k = int'(do_data[6:0]);
        if (rst) begin
            phase = 0;
            m_len = 0;
            pos   = 0;
        end else if (cen) begin
            if (do_start && n != 0) begin
                m_len = n;
                pos   = 0;
                phase = (n == 1 && k == 1) ? 0 : 1;
            end else if (do_start) begin
                if (m_len != 0) begin
                    phase = 2;
                    pos   = 0;
                end
            end else if (phase != 0 && !do_en) begin
                phase = 0;
            end else if (!pc_halt) begin
                if (phase == 1) begin
                    words[pos] = rom_data;
                    known[pos] = 1'b1;
                    pos++;
                    if (pos == m_len) begin
                        phase = do_flush ? 0 : 2;
                        pos   = 0;
                    end
                end else if (phase == 2) begin
                    if (do_flush) begin
                        phase = 0;
                        pos   = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        end
    endtask

    task automatic push_exp(string tag);
        exp_t e;
        int   idx;
        e.tag = tag;
        e.len = 4'(m_len);
        if (phase == 2) begin
            idx         = pos % m_len;
            e.instr     = words[idx];
            e.chk_instr = known[idx];
            e.rom_cs    = 1'b0;
            e.hit       = 1'b1;
        end else begin
            e.instr     = rom_data;
            e.chk_instr = 1'b1;
            e.rom_cs    = 1'b1;
            e.hit       = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit c, input bit ds, input logic [3:0] n,
                       input logic [6:0] k, input bit en, input bit fl, input bit hlt,
                       input logic [15:0] rom, input string tag);
        @(posedge clk);
        #1;
        model_edge();
        rst      = r;
        cen      = c;
        do_start = ds;
        do_data  = {n, k};
        do_en    = en;
        do_flush = fl;
        pc_halt  = hlt;
        rom_data = rom;
        push_exp(tag);
    endtask

    task automatic run(input bit ds, input logic [3:0] n, input logic [6:0] k,
                       input bit fl, input bit hlt, input logic [15:0] rom, input string tag);
        cyc(1'b0, 1'b1, ds, n, k, 1'b1, fl, hlt, rom, tag);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'($urandom), tag);
    endtask

    // Monitor: compare every presented output cycle against the scoreboard
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk_instr) chk($sformatf("%s.instr", mon_e.tag), instr, mon_e.instr);
            chk($sformatf("%s.rom_cs", mon_e.tag), 16'(rom_cs), 16'(mon_e.rom_cs));
            chk($sformatf("%s.hit", mon_e.tag), 16'(hit), 16'(mon_e.hit));
            chk($sformatf("%s.len", mon_e.tag), 16'(debug_len), 16'(mon_e.len));
        end
    end

    initial begin
        logic [15:0] body [15];
        rst = 1'b1; cen = 1'b1; do_start = 1'b0; do_data = '0;
        do_en = 1'b0; do_flush = 1'b0; pc_halt = 1'b0; rom_data = '0;

        cyc(1'b1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 16'h1234, "reset");
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 16'h5678, "reset");

        // redo with nothing cached
        run(1'b1, 4'd0, 7'd3, 1'b0, 1'b0, 16'h0F0F, "redo_empty");
        idle(2, "redo_empty_idle");

        // do N=3 K=4
        run(1'b1, 4'd3, 7'd4, 1'b0, 1'b0, 16'h0000, "do3_start");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WA, "do3_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WB, "do3_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WC, "do3_fill");
        for (int i = 0; i < 9; i++) run(1'b0, 4'd0, 7'd0, i == 8, 1'b0, 16'($urandom), "do3_replay");
        idle(2, "do3_after");

        // redo replays the same body
        run(1'b1, 4'd0, 7'd0, 1'b0, 1'b0, 16'h1111, "redo_start");
        for (int i = 0; i < 3; i++) run(1'b0, 4'd0, 7'd0, i == 2, 1'b0, 16'($urandom), "redo_replay");
        idle(2, "redo_after");

        // N=1 K=1 never replays
        run(1'b1, 4'd1, 7'd1, 1'b0, 1'b0, 16'h2222, "n1k1_start");
        idle(3, "n1k1_idle");

        // stall in the middle of replay
        run(1'b1, 4'd3, 7'd3, 1'b0, 1'b0, 16'h0000, "halt_start");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WA, "halt_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WB, "halt_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, WC, "halt_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h3333, "halt_rep");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 16'h3333, "halt_hold");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 16'h3333, "halt_hold");
        for (int i = 0; i < 5; i++) run(1'b0, 4'd0, 7'd0, i == 4, 1'b0, 16'h3333, "halt_rep");
        idle(2, "halt_after");

        // full-depth loop, N=15 K=2
        run(1'b1, 4'd15, 7'd2, 1'b0, 1'b0, 16'h0000, "n15_start");
        for (int i = 0; i < 15; i++) begin
            body[i] = 16'($urandom);
            run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, body[i], "n15_fill");
        end
        for (int i = 0; i < 15; i++) run(1'b0, 4'd0, 7'd0, i == 14, 1'b0, 16'($urandom), "n15_replay");
        idle(2, "n15_after");

        // new do together with flush while replaying
        run(1'b1, 4'd2, 7'd5, 1'b0, 1'b0, 16'h0000, "ds_fl_start");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h4444, "ds_fl_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h5555, "ds_fl_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h6666, "ds_fl_rep");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h6666, "ds_fl_rep");
        run(1'b1, 4'd4, 7'd2, 1'b1, 1'b0, 16'h6666, "ds_fl_both");
        for (int i = 0; i < 4; i++) run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h7000 + 16'(i), "ds_fl_fill2");
        for (int i = 0; i < 4; i++) run(1'b0, 4'd0, 7'd0, i == 3, 1'b0, 16'h7777, "ds_fl_rep2");
        idle(1, "ds_fl_after");

        // reset in the middle of a fill, then redo is ignored
        run(1'b1, 4'd5, 7'd3, 1'b0, 1'b0, 16'h0000, "rstfill_start");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h8001, "rstfill_fill");
        run(1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 16'h8002, "rstfill_fill");
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, 1'b0, 1'b0, 16'h8003, "rstfill_rst");
        run(1'b1, 4'd0, 7'd0, 1'b0, 1'b0, 16'h8004, "rstfill_redo");
        idle(2, "rstfill_after");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 14) == 0, 4'($urandom_range(0, 15)),
                7'($urandom_range(1, 3)), $urandom_range(0, 49) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                16'($urandom), "rand");
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
